display_scan_n: RTL
===================

Name: display_scan_n

Overview:
- Parametrised multiplexed 7-segment display driver for N digits; successor to the fixed 4-digit scan/decode chain.
- Adds a built-in prescaler, glitch-free double-buffered frame updates, per-digit blink, PWM brightness and a frame-done strobe.
- Sits between the datapath (hex/point/blank vectors) and the board AN/SEGMENT pins.
- AN and segment outputs are active-low (common-anode board).

Parameters:
- DIGITS, 4, number of digits scanned (2..16; need not be a power of 2).
- SCAN_DIV, 17, prescaler width; each digit slot lasts 2^SCAN_DIV clk cycles.
- BRIGHT_W, 4, brightness code width; must be <= SCAN_DIV.
- BLINK_DIV, 25, blink half-period is 2^BLINK_DIV cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- hexs  input  4*DIGITS  digit values; nibble i drives digit i.
- points  input  DIGITS  1 = decimal point lit on digit i.
- LEs  input  DIGITS  1 = digit i blanked.
- blink  input  DIGITS  1 = digit i blinks.
- bright  input  BRIGHT_W  brightness code; 0 = dark.
- load  input  1  1-cycle strobe; captures hexs/points/LEs/blink into the pending buffer.
- AN  output  DIGITS  digit enables, active-low.
- SEGMENT  output  8  {p,g,f,e,d,c,b,a}, active-low.
- frame_done  output  1  1-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Reset (rst=0, async): pre=0, idx=0, blink counter and phase=0, pending and active buffers=0, pend_valid=0, AN=all ones, SEGMENT=8'hFF, frame_done=0.
- Prescaler:
  - pre (SCAN_DIV bits) increments every cycle.
  - When pre is all ones, idx advances: idx=DIGITS-1 wraps to 0, else idx+1.
- Double buffer:
  - load=1 copies the inputs into pending and sets pend_valid; a later load overwrites pending.
  - On the cycle idx wraps to 0 with pend_valid=1: active<=pending and pend_valid<=0.
  - If load coincides with that wrap cycle, the new load data goes to pending and stays pending until the next wrap; the previous pending is committed.
  - A frame never mixes old and new data.
- frame_done pulses in the cycle idx wraps, registered with the outputs below.
- Blink: a BLINK_DIV-bit counter runs continuously; phase toggles when it reaches all ones.
- Digit dark condition (from active buffer): dark = LEs[idx] | (blink[idx] & phase) | ~pwm_on.
- PWM: pwm_on = (pre[SCAN_DIV-1 -: BRIGHT_W] < bright) or (bright all ones).
  - bright=0 gives a dark display.
  - bright all ones gives 100% on.
- Decode: hex nibble to a..g, standard 0-9, A, b, C, d, E, F; segment bit = 0 when lit.
  - Codes with p off: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
  - SEGMENT[7] = ~points[idx].
- Outputs are registered, 1-cycle latency from idx/pre/phase:
  - Digit lit: AN = ~(1<<idx), SEGMENT = decoded value.
  - Digit dark: AN = all ones, SEGMENT = 8'hFF.
- At most one AN bit is low at any time.
- Reset mid-frame returns to digit 0 and discards pending data.

Optional Feature:
- Macro DISPSCAN_PWM_EN.
- Defined: PWM brightness as described above.
- Undefined: pwm_on is tied to 1; the bright port is present but ignored, and the PWM compare logic is not synthesised.

Test Plan:
All scenarios use DIGITS=4, SCAN_DIV=4, BRIGHT_W=2, BLINK_DIV=8, bright=3 unless noted.
1. Reset: hold rst=0 -> AN=4'hF, SEGMENT=8'hFF, frame_done=0. Release with no load -> digits cycle AN E,D,B,7 every 16 cycles, all showing SEGMENT=C0.
2. Load hexs=16'hF3A1, points=4'b0010 mid-frame -> display unchanged until the next wrap. Next frame shows digit0=F9, digit1=88 & 7F=08, digit2=B0, digit3=8E; frame_done pulses once per 64 cycles.
3. DIGITS=3: idx sequence 0,1,2,0; AN sequence 6,5,3. Never all-low, never 3'b111 while lit.
4. LEs=4'b0100 -> AN bit2 never low; SEGMENT=FF during slot 2. blink=4'b0001 -> digit0 alternates lit/dark every 256 cycles.
5. With PWM enabled: bright=1 -> AN low only for pre<4 in each 16-cycle slot; bright=0 -> AN=F always; bright=3 -> 16/16 on.
6. Load during the wrap cycle -> that data appears one frame later. Assert rst mid-frame -> immediate AN=F; after release, idx=0 and active data is 0.

Source files
------------

// File: rtl/display_scan_n.sv
// display_scan_n: N-digit multiplexed 7-segment driver for a common-anode board.
// Built-in prescaler, double-buffered frame data, per-digit blink and blank,
// and a one-cycle frame_done strobe when the scan wraps back to digit 0.
// AN and SEGMENT ({p,g,f,e,d,c,b,a}) are active-low and registered.
// Optional feature macro: DISPSCAN_PWM_EN enables PWM brightness from `bright`;
// without it the display is always fully on and `bright` is ignored.
module display_scan_n #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 17,
  parameter int BRIGHT_W  = 4,
  parameter int BLINK_DIV = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     LEs,
  input  logic [DIGITS-1:0]     blink,
  input  logic [BRIGHT_W-1:0]   bright,
  input  logic                  load,
  output logic [DIGITS-1:0]     AN,
  output logic [7:0]            SEGMENT,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  logic [SCAN_DIV-1:0]  pre;
  logic [IW-1:0]        idx;
  logic [BLINK_DIV-1:0] blink_cnt;
  logic                 phase;

  logic [4*DIGITS-1:0]  pend_hexs, act_hexs;
  logic [DIGITS-1:0]    pend_points, act_points;
  logic [DIGITS-1:0]    pend_les, act_les;
  logic [DIGITS-1:0]    pend_blink, act_blink;
  logic                 pend_valid;

  logic                 slot_end;
  logic                 wrap;
  logic                 pwm_on;
  logic                 dark;
  logic [3:0]           cur_hex;
  logic                 cur_point;

  assign slot_end = &pre;
  assign wrap     = slot_end && (idx == LAST);

`ifdef DISPSCAN_PWM_EN
  // Top prescaler bits act as the PWM ramp within each digit slot
  assign pwm_on = (pre[SCAN_DIV-1 -: BRIGHT_W] < bright) || (&bright);
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign pwm_on        = 1'b1;
`endif

  function automatic logic [6:0] decode(input logic [3:0] h);
    logic [6:0] s;
    s = '1;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Select the current digit's data from the active buffer and decide darkness
  always_comb begin
    cur_hex   = act_hexs[4*int'(idx) +: 4];
    cur_point = act_points[idx];
    dark      = act_les[idx] | (act_blink[idx] & phase) | ~pwm_on;
  end

  // Prescaler, scan index and blink phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre       <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      pre       <= pre + 1'b1;
      if (slot_end) idx <= (idx == LAST) ? '0 : idx + 1'b1;
      blink_cnt <= blink_cnt + 1'b1;
      if (&blink_cnt) phase <= ~phase;
    end
  end

  // Capture into pending on load; commit pending to active only at frame wrap.
  // A load on the wrap cycle lands in pending after the old pending commits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_hexs   <= '0;
      pend_points <= '0;
      pend_les    <= '0;
      pend_blink  <= '0;
      pend_valid  <= 1'b0;
      act_hexs    <= '0;
      act_points  <= '0;
      act_les     <= '0;
      act_blink   <= '0;
    end else begin
      if (wrap && pend_valid) begin
        act_hexs   <= pend_hexs;
        act_points <= pend_points;
        act_les    <= pend_les;
        act_blink  <= pend_blink;
        pend_valid <= 1'b0;
      end
      if (load) begin
        pend_hexs   <= hexs;
        pend_points <= points;
        pend_les    <= LEs;
        pend_blink  <= blink;
        pend_valid  <= 1'b1;
      end
    end
  end

  // Registered pin drivers and frame strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      AN         <= '1;
      SEGMENT    <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (dark) begin
        AN      <= '1;
        SEGMENT <= '1;
      end else begin
        AN      <= ~(DIGITS'(1) << idx);
        SEGMENT <= {~cur_point, decode(cur_hex)};
      end
    end
  end

endmodule
